timed_memory: RTL
=================

TIMED_MEMORY -- requirements
Module: timed_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 32-bit words in the array; power of two, 16..65536.
REQ-002 Parameter READ_LATENCY, default 1: cycles from read request to ReadValid; legal range 1..8.
REQ-003 Parameter HALT_ADDR, default 32'hFFFF_FFF0: byte address of the halt (tohost) register.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 nRst  input  1  reset, synchronous, active-low.
REQ-006 ReadReq  input  1  read request strobe for ReadAddr this cycle.
REQ-007 ReadAddr  input  32  byte address; bits [1:0] ignored.
REQ-008 WriteAddr  input  32  byte address; bits [1:0] ignored.
REQ-009 WriteData  input  32  write data, little-endian byte lanes.
REQ-010 Wstrb  input  4  byte enables; 4'b0000 means no write.
REQ-011 ReadData  output  32  read result, valid only with ReadValid.
REQ-012 ReadValid  output  1  one-cycle pulse per accepted ReadReq.
REQ-013 LastData  output  32  full 32-bit word most recently written (post-merge value).
REQ-014 Halt  output  1  sticky; set by any write to HALT_ADDR.
REQ-015 HaltCode  output  32  WriteData captured by the halting write.
REQ-016 ErrCnt  output  8  count of out-of-range accesses, saturating.

Function
REQ-017 Word index = Addr[31:2]; in range when index < DEPTH_WORDS.
REQ-018 Writes: each lane i with Wstrb[i]=1 updates byte i of the addressed word at the clock edge; other lanes unchanged.
REQ-019 Reads: data is sampled at the edge of the ReadReq cycle and appears on ReadData with ReadValid exactly READ_LATENCY cycles later.
REQ-020 Fully pipelined: one ReadReq accepted every cycle, no stall; responses return in request order.
REQ-021 Same-cycle read and write to the same word: read returns the pre-write contents.
REQ-022 Out-of-range read: returns 32'hDEAD_BEEF with normal latency; ErrCnt increments.
REQ-023 Out-of-range write with Wstrb != 0: array unchanged; ErrCnt increments.
REQ-024 Out-of-range read and write in the same cycle: ErrCnt increments by 2.
REQ-025 ErrCnt saturates at 255; no wrap.
REQ-026 Write to HALT_ADDR with Wstrb != 0: Halt=1 next cycle, HaltCode=WriteData; array untouched; not an error.
REQ-027 Later halt writes leave HaltCode unchanged (first code wins).
REQ-028 Reads of HALT_ADDR return HaltCode (0 before halt).
REQ-029 LastData updates one cycle after every in-range write with the merged word.
REQ-030 While ReadValid=0, ReadData holds its last value.

Reset
REQ-031 Sampled low at an edge: ReadValid=0, ReadData=0, LastData=0, Halt=0, HaltCode=0, ErrCnt=0 after that edge.
REQ-032 In-flight reads are discarded; no ReadValid pulse for any request made before or during reset.
REQ-033 Array contents are not cleared by reset.
REQ-034 Reads and writes presented while nRst=0 are ignored.

Structure
REQ-035 Shared package holds the DEAD_BEEF fill constant, default HALT_ADDR, and the READ_LATENCY bounds.
REQ-036 Sub-module mem_delay_line (parameter DEPTH, 33-bit valid+data shift register with synchronous clear) implements the latency pipe.
REQ-037 Elaboration fails if READ_LATENCY is outside 1..8 or DEPTH_WORDS is not a power of two.

Verification
REQ-038 READ_LATENCY=3: write 0x12345678 to 0x40 (Wstrb=F), ReadReq 0x40 at cycle t -> ReadValid and ReadData=0x12345678 at t+3 only.
REQ-039 Word 0x40=0x12345678, write 0xAABBCCDD with Wstrb=4'b0101 -> read returns 0x12BB56DD; LastData=0x12BB56DD.
REQ-040 Back-to-back ReadReq to 0x0,0x4,0x8 for three cycles -> three consecutive ReadValid pulses, data in order.
REQ-041 Read 0x0010_0000 (DEPTH 4096) -> 0xDEADBEEF, ErrCnt=1; 300 more out-of-range writes -> ErrCnt=255.
REQ-042 Write 0x1 then 0x2 to HALT_ADDR -> Halt=1, HaltCode=0x1; reset -> Halt=0, array data retained.
REQ-043 ReadReq at t, nRst low at t+1 (READ_LATENCY=4) -> no ReadValid pulse at t+4.

Source files
------------

// File: rtl/timed_memory_pkg.sv
// Shared constants, types and helpers for the timed_memory word store.
package timed_memory_pkg;

  localparam logic [31:0] FILL_WORD         = 32'hDEAD_BEEF;
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'hFFFF_FFF0;
  localparam int unsigned MIN_READ_LATENCY  = 1;
  localparam int unsigned MAX_READ_LATENCY  = 8;
  localparam logic [7:0]  ERR_CNT_MAX       = 8'hFF;

  // One slot of the read-latency pipe: 33 bits, valid flag on top.
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } pipeEntry_t;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = newWord[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/timed_memory_delay_line.sv
// Fixed-depth valid+data shift register that gives read responses their latency.
module mem_delay_line
  import timed_memory_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic       Clk,
  input  logic       Clear,
  input  pipeEntry_t InEntry,
  output pipeEntry_t OutEntry
);

  pipeEntry_t stage [DEPTH];

  // Data only advances alongside a valid flag, so the last stage keeps
  // presenting the most recent response while idle bubbles pass through.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0].valid <= InEntry.valid;
      if (InEntry.valid) stage[0].data <= InEntry.data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i].valid <= stage[i-1].valid;
        if (stage[i-1].valid) stage[i].data <= stage[i-1].data;
      end
    end
  end

  assign OutEntry = stage[DEPTH-1];

endmodule

// File: rtl/timed_memory.sv
// Byte-writable word memory with fixed read latency, halt (tohost) register
// and a saturating count of out-of-range accesses.
module timed_memory
  import timed_memory_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic        ReadReq,
  input  logic [31:0] ReadAddr,
  input  logic [31:0] WriteAddr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  Wstrb,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic [31:0] LastData,
  output logic        Halt,
  output logic [31:0] HaltCode,
  output logic [7:0]  ErrCnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : gBadLatency
    $error("timed_memory: READ_LATENCY must be within 1..8");
  end
  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : gBadDepth
    $error("timed_memory: DEPTH_WORDS must be a power of two within 16..65536");
  end

  logic [31:0] mem [DEPTH_WORDS];

  logic          readHalt, readInRange, readErr;
  logic          writeActive, writeHalt, writeInRange, writeErr, writeMem;
  logic [AW-1:0] readIdx, writeIdx;
  logic [31:0]   readWord, mergedWord;
  logic [1:0]    errInc;
  logic [8:0]    errSum;
  logic [7:0]    errCntNext;
  pipeEntry_t    pipeIn, pipeOut;
  logic          unusedAddrBits;

  assign unusedAddrBits = ^{ReadAddr[1:0], WriteAddr[1:0]};

  assign readIdx      = ReadAddr[AW+1:2];
  assign writeIdx     = WriteAddr[AW+1:2];
  assign readHalt     = ReadAddr[31:2] == HALT_ADDR[31:2];
  assign readInRange  = ReadAddr[31:2] < 30'(DEPTH_WORDS);
  assign readErr      = ReadReq && !readHalt && !readInRange;

  assign writeActive  = Wstrb != 4'b0000;
  assign writeHalt    = writeActive && WriteAddr[31:2] == HALT_ADDR[31:2];
  assign writeInRange = WriteAddr[31:2] < 30'(DEPTH_WORDS);
  assign writeErr     = writeActive && !writeHalt && !writeInRange;
  assign writeMem     = nRst && writeActive && !writeHalt && writeInRange;
  assign mergedWord   = mergeBytes(mem[writeIdx], WriteData, Wstrb);

  // Read source is taken before this edge's write lands, so a same-cycle
  // read of the word being written returns the old contents.
  always_comb begin
    readWord = FILL_WORD;
    if (readHalt)         readWord = HaltCode;
    else if (readInRange) readWord = mem[readIdx];
  end

  // NOTE: the array has no reset branch; contents survive reset and the
  // storage can map onto plain RAM without a clear port.
  always_ff @(posedge Clk) begin
    if (writeMem) mem[writeIdx] <= mergedWord;
  end

  always_comb begin
    errInc     = 2'(readErr) + 2'(writeErr);
    errSum     = {1'b0, ErrCnt} + 9'(errInc);
    errCntNext = errSum[8] ? ERR_CNT_MAX : errSum[7:0];
  end

  always_ff @(posedge Clk) begin
    if (!nRst) begin
      LastData <= '0;
      Halt     <= 1'b0;
      HaltCode <= '0;
      ErrCnt   <= '0;
    end else begin
      if (writeMem) LastData <= mergedWord;
      if (writeHalt) begin
        Halt <= 1'b1;
        if (!Halt) HaltCode <= WriteData;
      end
      ErrCnt <= errCntNext;
    end
  end

  assign pipeIn.valid = ReadReq && nRst;
  assign pipeIn.data  = readWord;

  mem_delay_line #(
    .DEPTH (READ_LATENCY)
  ) uDelay (
    .Clk      (Clk),
    .Clear    (!nRst),
    .InEntry  (pipeIn),
    .OutEntry (pipeOut)
  );

  assign ReadValid = pipeOut.valid;
  assign ReadData  = pipeOut.data;

endmodule
